// File: rtl/esl_to_binary.sv
// ESL bitstream-pair decoder: counts ones on x/y over a 2^CNT_W window, then divides the bipolar values.
// Define ESL_DEC_ROUND_EN for one extra quotient bit with round-half-away-from-zero.
`ifndef BIN_LEN
`define BIN_LEN 4
`endif

module esl_to_binary #(
    parameter int CNT_W  = `BIN_LEN,
    parameter int FRAC_W = `BIN_LEN - 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              in_x,
    input  logic              in_y,
    output logic              busy,
    output logic              out_valid,
    output logic [FRAC_W+1:0] out_val,
    output logic              div_by_zero
);

    localparam int OUT_W = FRAC_W + 2;
    localparam int BV_W  = CNT_W + 2;
`ifdef ESL_DEC_ROUND_EN
    localparam int Q_W   = FRAC_W + 2;
`else
    localparam int Q_W   = FRAC_W + 1;
`endif
    localparam int IT_W  = $clog2(Q_W + 1);

    localparam logic [BV_W-1:0]  N_VAL     = BV_W'(1) << CNT_W;
    localparam logic [OUT_W-1:0] SAT_MAG   = {1'b0, {(FRAC_W+1){1'b1}}};
    localparam logic [CNT_W-1:0] WIN_LAST  = {CNT_W{1'b1}};
    localparam logic [IT_W-1:0]  ITER_LAST = IT_W'(Q_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W:0]     cx_q, cx_d;
    logic [CNT_W:0]     cy_q, cy_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [IT_W-1:0]    iter_q, iter_d;
    logic [BV_W-1:0]    rem_q, rem_d;
    logic [Q_W-1:0]     quot_q, quot_d;
    logic [OUT_W-1:0]   out_val_q, out_val_d;
    logic               dbz_q, dbz_d;

    // Bipolar values are formed straight from the counters, which hold still during DIVIDE.
    logic [BV_W-1:0]    bx, by;
    logic [BV_W-1:0]    bx_mag, by_mag;
    logic               sign;
    logic               by_zero, bx_zero, sat_cond;
    logic [OUT_W-1:0]   sat_signed;

    assign bx       = {cx_q, 1'b0} - N_VAL;
    assign by       = {cy_q, 1'b0} - N_VAL;
    assign bx_mag   = bx[BV_W-1] ? -bx : bx;
    assign by_mag   = by[BV_W-1] ? -by : by;
    assign sign     = bx[BV_W-1] ^ by[BV_W-1];
    assign by_zero  = (by_mag == '0);
    assign bx_zero  = (bx_mag == '0);
    assign sat_cond = (bx_mag >= (by_mag << 1));
    assign sat_signed = sign ? -SAT_MAG : SAT_MAG;

    // Restoring division step: first cycle starts from |bx|, the quotient's 2^0 bit.
    logic [BV_W-1:0]    r_in;
    logic               q_bit;
    logic [BV_W-1:0]    rem_next;
    logic [Q_W-1:0]     quot_next;
    logic [OUT_W-1:0]   div_mag;
    logic [OUT_W-1:0]   div_signed;

    assign r_in      = (iter_q == '0) ? bx_mag : (rem_q << 1);
    assign q_bit     = (r_in >= by_mag);
    assign rem_next  = q_bit ? (r_in - by_mag) : r_in;
    assign quot_next = (quot_q << 1) | Q_W'(q_bit);

`ifdef ESL_DEC_ROUND_EN
    logic [OUT_W-1:0]   q_rnd;
    assign q_rnd   = {1'b0, quot_next[Q_W-1:1]} + OUT_W'(quot_next[0]);
    assign div_mag = (q_rnd > SAT_MAG) ? SAT_MAG : q_rnd;
`else
    assign div_mag = {1'b0, quot_next};
`endif
    assign div_signed = sign ? -div_mag : div_mag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            win_q     <= '0;
            iter_q    <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            out_val_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            win_q     <= win_d;
            iter_q    <= iter_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            out_val_q <= out_val_d;
            dbz_q     <= dbz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        win_d     = win_q;
        iter_d    = iter_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        out_val_d = out_val_q;
        dbz_d     = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    win_d   = '0;
                    iter_d  = '0;
                    rem_d   = '0;
                    quot_d  = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (enable) begin
                    cx_d  = cx_q + {{CNT_W{1'b0}}, in_x};
                    cy_d  = cy_q + {{CNT_W{1'b0}}, in_y};
                    win_d = win_q + CNT_W'(1);
                    if (win_q == WIN_LAST) begin
                        state_d = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                if ((iter_q == '0) && by_zero) begin
                    dbz_d     = 1'b1;
                    out_val_d = bx_zero ? '0 : sat_signed;
                    state_d   = S_DONE;
                end else if ((iter_q == '0) && sat_cond) begin
                    dbz_d     = 1'b0;
                    out_val_d = sat_signed;
                    state_d   = S_DONE;
                end else begin
                    rem_d  = rem_next;
                    quot_d = quot_next;
                    iter_d = iter_q + IT_W'(1);
                    if (iter_q == ITER_LAST) begin
                        dbz_d     = 1'b0;
                        out_val_d = div_signed;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_val     = out_val_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_esl_to_binary.sv
// Randomized bench for esl_to_binary (CNT_W=4, FRAC_W=3) against an arithmetic reference model.
// Model follows ESL_DEC_ROUND_EN when the macro is defined for the build.
module tb_esl_to_binary;

    localparam int CNT_W  = 4;
    localparam int FRAC_W = 3;
    localparam int N      = 1 << CNT_W;
    localparam int OUT_W  = FRAC_W + 2;
    localparam int SAT    = (1 << (FRAC_W + 1)) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             start;
    logic             in_x;
    logic             in_y;
    logic             busy;
    logic             out_valid;
    logic [OUT_W-1:0] out_val;
    logic             div_by_zero;

    int checks   = 0;
    int failures = 0;

    // Expected results: {div_by_zero, out_val}, plus the out_valid cycle.
    logic [OUT_W:0] exp_q[$];
    int             lat_q[$];

    esl_to_binary #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .in_x       (in_x),
        .in_y       (in_y),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_val    (out_val),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result as real-number arithmetic on the ones counts, then quantized.
    function automatic logic [OUT_W:0] model(input int nx, input int ny);
        int bx, by, ax, ay, mag, val;
        bit neg;
        bx  = 2 * nx - N;
        by  = 2 * ny - N;
        ax  = (bx < 0) ? -bx : bx;
        ay  = (by < 0) ? -by : by;
        neg = (bx < 0) != (by < 0);
        if (by == 0) begin
            val = (bx == 0) ? 0 : (neg ? -SAT : SAT);
            return {1'b1, OUT_W'(val)};
        end
        if (ax >= 2 * ay) begin
            mag = SAT;
        end else begin
`ifdef ESL_DEC_ROUND_EN
            mag = (ax * (1 << (FRAC_W + 1)) + ay) / (2 * ay);
            if (mag > SAT) mag = SAT;
`else
            mag = (ax * (1 << FRAC_W)) / ay;
`endif
        end
        val = neg ? -mag : mag;
        return {1'b0, OUT_W'(val)};
    endfunction

    function automatic int latency(input int nx, input int ny);
        int bx, by, ax, ay;
        bx = 2 * nx - N;
        by = 2 * ny - N;
        ax = (bx < 0) ? -bx : bx;
        ay = (by < 0) ? -by : by;
        if (ay == 0 || ax >= 2 * ay) return N + 2;
`ifdef ESL_DEC_ROUND_EN
        return N + FRAC_W + 3;
`else
        return N + FRAC_W + 2;
`endif
    endfunction

    function automatic logic [N-1:0] mask_of(input int n);
        logic [N-1:0] m = '0;
        while ($countones(m) < n) m[$urandom_range(N-1, 0)] = 1'b1;
        return m;
    endfunction

    task automatic run_window(input int nx, input int ny, input int gap_pos,
                              input int gap_len, input bit spam);
        logic [N-1:0]   xm, ym;
        logic [2:0]     seq[$];
        logic [OUT_W:0] exp_v, got_exp;
        int             exp_lat, got_lat, cyc;
        bit             seen;
        xm = mask_of(nx);
        ym = mask_of(ny);
        for (int s = 0; s < N; s++) begin
            if (s == gap_pos)
                for (int g = 0; g < gap_len; g++) seq.push_back({1'b0, 2'($urandom_range(3, 0))});
            seq.push_back({1'b1, xm[s], ym[s]});
        end
        exp_v   = model(nx, ny);
        exp_lat = latency(nx, ny) + gap_len;
        exp_q.push_back(exp_v);
        lat_q.push_back(exp_lat);

        @(posedge clock); #1;
        start = 1'b1;
        {enable, in_x, in_y} = 3'($urandom_range(7, 0));
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == 1) check_eq("busy_in_accum", busy, 1);
            if (out_valid) begin
                seen    = 1'b1;
                got_exp = exp_q.pop_front();
                got_lat = lat_q.pop_front();
                check_eq("out_val", out_val, got_exp[OUT_W-1:0]);
                check_eq("div_by_zero", div_by_zero, got_exp[OUT_W]);
                check_eq("latency", cyc, got_lat);
                start = spam;
            end else begin
                start = spam ? 1'($urandom_range(1, 0)) : 1'b0;
                if (seq.size() > 0) {enable, in_x, in_y} = seq.pop_front();
                else {enable, in_x, in_y} = 3'($urandom_range(7, 0));
            end
        end
        check_eq("out_valid_seen", seen, 1);
        @(posedge clock); #1;
        check_eq("idle_after_done", busy, 0);
        check_eq("pulse_one_cycle", out_valid, 0);
        check_eq("out_val_held", out_val, exp_v[OUT_W-1:0]);
        start = 1'b0;
    endtask

    int dir_nx[10]  = '{16, 12, 4, 16, 8, 16, 0, 10, 10, 16};
    int dir_ny[10]  = '{16, 16, 16, 8, 8, 12, 12, 14, 14, 16};
    int dir_gap[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 5};

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        start  = 1'b0;
        in_x   = 1'b0;
        in_y   = 1'b0;
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_val", out_val, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_window(dir_nx[i], dir_ny[i], 7, dir_gap[i], 1'b0);
        run_window(12, 16, 3, 0, 1'b1);

        // Reset in the middle of a window discards it.
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
        enable = 1'b1;
        in_x   = 1'b1;
        in_y   = 1'b1;
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        #2;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_out_val", out_val, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_dbz", div_by_zero, 0);
        reset = 1'b0;
        run_window(16, 16, 0, 0, 1'b0);

        for (int i = 0; i < 24; i++)
            run_window($urandom_range(N, 0), $urandom_range(N, 0), $urandom_range(N-1, 0),
                       $urandom_range(3, 0), 1'($urandom_range(1, 0)));

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
